// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one simple-dual-port block RAM between requesters A and B.
// Optional power-up clear sweep enabled by defining RAM_ARB_CLEAR_EN.
`timescale 1ns/1ps
module ram_port_arbiter #(
  parameter int                ADDR_W    = 9,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [DATA_W-1:0] ram_di,
  output logic              ram_rden,
  output logic [ADDR_W-1:0] ram_rdaddr,
  input  logic [DATA_W-1:0] ram_do,
  output logic              busy
);

  logic              last_b_q, last_b_d;
  logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_hold_q, a_hold_d, b_hold_q, b_hold_d;
  logic              run;

`ifdef RAM_ARB_CLEAR_EN
  typedef enum logic {S_CLEAR, S_RUN} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              sweep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == S_CLEAR) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == {ADDR_W{1'b1}}) state_d = S_RUN;
    end
  end

  assign run   = (state_q == S_RUN);
  // Write enable must read 0 while reset is held, even though the state sits in CLEAR.
  assign sweep = (state_q == S_CLEAR) & rst_n;
  assign busy  = ~run;
`else
  assign run  = 1'b1;
  assign busy = 1'b0;
`endif

  // Gated by rst_n so no grant escapes while reset is asserted with a request pending.
  assign a_gnt = run & rst_n & a_req & (~b_req | last_b_q);
  assign b_gnt = run & rst_n & b_req & (~a_req | ~last_b_q);

  always_comb begin
    ram_wren   = 1'b0;
    ram_wraddr = '0;
    ram_di     = '0;
    ram_rden   = 1'b0;
    ram_rdaddr = '0;
`ifdef RAM_ARB_CLEAR_EN
    if (sweep) begin
      ram_wren   = 1'b1;
      ram_wraddr = clr_addr_q;
      ram_di     = CLEAR_VAL;
    end else
`endif
    if (a_gnt) begin
      if (a_we) begin
        ram_wren   = 1'b1;
        ram_wraddr = a_addr;
        ram_di     = a_wdata;
      end else begin
        ram_rden   = 1'b1;
        ram_rdaddr = a_addr;
      end
    end else if (b_gnt) begin
      if (b_we) begin
        ram_wren   = 1'b1;
        ram_wraddr = b_addr;
        ram_di     = b_wdata;
      end else begin
        ram_rden   = 1'b1;
        ram_rdaddr = b_addr;
      end
    end
  end

  always_comb begin
    last_b_d   = last_b_q;
    if (a_gnt) last_b_d = 1'b0;
    if (b_gnt) last_b_d = 1'b1;
    a_rvalid_d = a_gnt & ~a_we;
    b_rvalid_d = b_gnt & ~b_we;
    a_hold_d   = a_rvalid_q ? ram_do : a_hold_q;
    b_hold_d   = b_rvalid_q ? ram_do : b_hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q   <= 1'b1;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_hold_q   <= '0;
      b_hold_q   <= '0;
    end else begin
      last_b_q   <= last_b_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_hold_q   <= a_hold_d;
      b_hold_q   <= b_hold_d;
    end
  end

  // The RAM output register already holds the data, so pass it straight through on the valid cycle.
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rvalid_q ? ram_do : a_hold_q;
  assign b_rdata  = b_rvalid_q ? ram_do : b_hold_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM model, per-cycle behavioural reference check, directed and random traffic.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 512;
`ifdef RAM_ARB_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic              clk, rst_n;
  logic              a_req, a_we, b_req, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic              a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic              ram_wren, ram_rden, busy;
  logic [ADDR_W-1:0] ram_wraddr, ram_rdaddr;
  logic [DATA_W-1:0] ram_di, ram_do;

  int total = 0;
  int bad   = 0;

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_wren(ram_wren), .ram_wraddr(ram_wraddr), .ram_di(ram_di),
    .ram_rden(ram_rden), .ram_rdaddr(ram_rdaddr), .ram_do(ram_do),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_word(input int i);
    return 32'hC0DE_0000 ^ (i * 32'h0001_0003);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Block RAM model: registered read, write visible to reads on later cycles.
  logic [DATA_W-1:0] ram_mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_word(i);
    ram_do <= '0;
    forever begin
      @(posedge clk);
      if (ram_wren) ram_mem[ram_wraddr] <= ram_di;
      if (ram_rden) ram_do <= ram_mem[ram_rdaddr];
    end
  end

  // Reference model: expected memory contents, tie-break memory, and pending read results.
  logic [DATA_W-1:0] shadow [DEPTH];
  logic              last_b = 1'b1;
  logic              m_ga = 1'b0, m_gb = 1'b0;
  logic              pa_v = 1'b0, pb_v = 1'b0;
  logic [DATA_W-1:0] pa_d = '0, pb_d = '0, ea_rd = '0, eb_rd = '0;
  int                clr_cnt = DEPTH;

  initial begin
    logic [ADDR_W-1:0] g_addr;
    logic              g_we;
    logic [DATA_W-1:0] g_data;
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_a_gnt", a_gnt, 0);        chk("rst_b_gnt", b_gnt, 0);
        chk("rst_a_rvalid", a_rvalid, 0);  chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_a_rdata", a_rdata, 0);    chk("rst_b_rdata", b_rdata, 0);
        chk("rst_wren", ram_wren, 0);      chk("rst_rden", ram_rden, 0);
        chk("rst_wraddr", ram_wraddr, 0);  chk("rst_rdaddr", ram_rdaddr, 0);
        chk("rst_di", ram_di, 0);          chk("rst_busy", busy, CLEAR_EN);
        pa_v = 0; pb_v = 0; ea_rd = '0; eb_rd = '0; last_b = 1'b1;
        m_ga = 0; m_gb = 0;
        clr_cnt = CLEAR_EN ? 0 : DEPTH;
      end else begin
        if (pa_v) ea_rd = pa_d;
        if (pb_v) eb_rd = pb_d;
        chk("a_rvalid", a_rvalid, pa_v);   chk("a_rdata", a_rdata, ea_rd);
        chk("b_rvalid", b_rvalid, pb_v);   chk("b_rdata", b_rdata, eb_rd);
        pa_v = 0; pb_v = 0;
        if (clr_cnt < DEPTH) begin
          chk("clr_busy", busy, 1);        chk("clr_a_gnt", a_gnt, 0);
          chk("clr_b_gnt", b_gnt, 0);      chk("clr_wren", ram_wren, 1);
          chk("clr_wraddr", ram_wraddr, clr_cnt);
          chk("clr_di", ram_di, 0);        chk("clr_rden", ram_rden, 0);
          shadow[clr_cnt] = '0;
          clr_cnt++;
          m_ga = 0; m_gb = 0;
        end else begin
          m_ga = a_req && (!b_req || last_b);
          m_gb = b_req && !m_ga;
          chk("busy", busy, 0);
          chk("a_gnt", a_gnt, m_ga);       chk("b_gnt", b_gnt, m_gb);
          g_we   = m_ga ? a_we    : b_we;
          g_addr = m_ga ? a_addr  : b_addr;
          g_data = m_ga ? a_wdata : b_wdata;
          chk("wren", ram_wren, (m_ga || m_gb) && g_we);
          chk("rden", ram_rden, (m_ga || m_gb) && !g_we);
          if (m_ga || m_gb) begin
            $display("txn t=%0t %s %s addr=%03h wdata=%08h", $time, m_ga ? "A" : "B",
                     g_we ? "WR" : "RD", g_addr, g_data);
            if (g_we) begin
              chk("wraddr", ram_wraddr, g_addr);
              chk("di", ram_di, g_data);
              shadow[g_addr] = g_data;
            end else begin
              chk("rdaddr", ram_rdaddr, g_addr);
              if (m_ga) begin pa_v = 1; pa_d = shadow[g_addr]; end
              else      begin pb_v = 1; pb_d = shadow[g_addr]; end
            end
            last_b = m_gb;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit is_b, output int n);
    n = 0;
    @(negedge clk);
    while (!(is_b ? b_gnt : a_gnt) && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 2000) chk(is_b ? "b_gnt_timeout" : "a_gnt_timeout", n, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 2000) chk("busy_timeout", n, 0);
  endtask

  initial begin
    int n;
    rst_n = 0;
    a_req = 1; a_we = 1; a_addr = 9'h005; a_wdata = 32'hDEADBEEF;
    b_req = 0; b_we = 0; b_addr = '0;     b_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Request held from reset: granted at once, or on the cycle the sweep ends.
    wait_gnt(0, n);
    chk("first_gnt_wait", n, CLEAR_EN ? DEPTH : 0);
    chk("first_gnt_busy", busy, 0);
    step();
    a_we = 0;
    wait_gnt(0, n);
    chk("t1_rd_gnt_wait", n, 0);
    step();
    a_req = 0;
    @(negedge clk);
    chk("t1_rvalid", a_rvalid, 1);
    chk("t1_rdata", a_rdata, 32'hDEADBEEF);
    chk("t1_b_rvalid", b_rvalid, 0);

    if (CLEAR_EN) begin
      step();
      a_req = 1; a_we = 0; a_addr = 9'h0AB;
      wait_gnt(0, n);
      step();
      a_req = 0;
      @(negedge clk);
      chk("t5_cleared", a_rdata, 32'h0000_0000);
    end

    // B writes the top address, A reads it on the very next cycle.
    step();
    b_req = 1; b_we = 1; b_addr = 9'h1FF; b_wdata = 32'h12345678;
    wait_gnt(1, n);
    chk("t3_b_gnt_wait", n, 0);
    step();
    b_req = 0;
    a_req = 1; a_we = 0; a_addr = 9'h1FF;
    wait_gnt(0, n);
    chk("t3_a_gnt_wait", n, 0);
    step();
    a_req = 0;
    @(negedge clk);
    chk("t3_rdata", a_rdata, 32'h12345678);

    // Read granted, then reset next cycle: its data must never surface.
    step();
    a_req = 1; a_we = 0; a_addr = 9'h005;
    wait_gnt(0, n);
    step();
    rst_n = 0; a_req = 0;
    @(negedge clk);
    chk("t4_no_rvalid", a_rvalid, 0);
    step();
    step();
    a_req = 1; a_we = 0; a_addr = 9'h010;
    b_req = 1; b_we = 0; b_addr = 9'h020;
    rst_n = 1;
    wait_idle();
    chk("t4_rvalid_after", a_rvalid, 0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      chk("t2_gnt_seq", {a_gnt, b_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
    end
    step();
    a_req = 0; b_req = 0;

    for (int c = 0; c < 2000; c++) begin
      step();
      if (!rst_n) rst_n = 1;
      else if (!CLEAR_EN && $urandom_range(0, 299) == 0) rst_n = 0;
      if (!a_req || m_ga) begin
        a_req   = ($urandom_range(0, 3) != 0);
        a_we    = $urandom_range(0, 1);
        a_addr  = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom_range(0, DEPTH - 1))
                                              : ADDR_W'($urandom_range(0, 15));
        a_wdata = $urandom;
      end
      if (!b_req || m_gb) begin
        b_req   = ($urandom_range(0, 3) != 0);
        b_we    = $urandom_range(0, 1);
        b_addr  = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom_range(0, DEPTH - 1))
                                              : ADDR_W'($urandom_range(0, 15));
        b_wdata = $urandom;
      end
    end
    step();
    a_req = 0; b_req = 0; rst_n = 1;
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
